// File: rtl/writeback_stage.sv
// writeback_stage
//   Final (WB) stage of the MIPS-lite 5-stage pipeline. Latches the MEM/WB
//   pipeline register and drives the register-file write port. It also keeps
//   a two-entry history of committed destinations for decode-stage hazard
//   checks, counts retired instructions, and runs the halt-completion FSM.
//
// Ports
//   clock, rst       : posedge clock, asynchronous active-low reset
//   valid_i          : MEM stage presents a real instruction this cycle
//   reg_write_i      : instruction writes a register
//   wb_mux_i         : 1 = ALU result, 0 = memory load data
//   load_i           : instruction is a load (statistics only)
//   halt_i           : instruction is HALT
//   rd_i             : destination register index
//   alu_result_i     : ALU result from the MEM stage
//   mem_data_i       : load data from the MEM stage
//   pc_i             : PC of the instruction
//   wr_en            : register-file write enable
//   input_read       : register-file write index
//   wr_data          : register-file write data
//   wb_pc            : PC of the instruction in WB
//   hist_rd          : {previous, newest} committed destinations
//   hist_vld         : valid bit per history entry
//   retired_cnt      : instructions retired, HALT included
//   regwrite_cnt     : retired instructions that wrote a register
//   load_cnt         : retired loads
//   halted           : HALT has retired; the pipeline may stop

module writeback_stage #(
  parameter int DATA               = 32,
  parameter int REG_WIDTH          = 5,
  parameter int ADD_WIDTH          = 32,
  parameter bit ZERO_REG_HARDWIRED = 1'b0
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   reg_write_i,
  input  logic                   wb_mux_i,
  input  logic                   load_i,
  input  logic                   halt_i,
  input  logic [REG_WIDTH-1:0]   rd_i,
  input  logic [DATA-1:0]        alu_result_i,
  input  logic [DATA-1:0]        mem_data_i,
  input  logic [ADD_WIDTH-1:0]   pc_i,
  output logic                   wr_en,
  output logic [REG_WIDTH-1:0]   input_read,
  output logic [DATA-1:0]        wr_data,
  output logic [ADD_WIDTH-1:0]   wb_pc,
  output logic [2*REG_WIDTH-1:0] hist_rd,
  output logic [1:0]             hist_vld,
  output logic [31:0]            retired_cnt,
  output logic [31:0]            regwrite_cnt,
  output logic [31:0]            load_cnt,
  output logic                   halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic retire_now;
  logic write_now;
  logic halt_now;

  // Halt-completion state register. HALTED is left only through reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Decide what this capture does. Only RUN-state captures of a real
  // instruction retire. A HALT never writes the register file, and with a
  // hardwired zero register a write to r0 is dropped but still retires.
  always_comb begin
    next_state = state;
    retire_now = 1'b0;
    halt_now   = 1'b0;
    write_now  = 1'b0;
    if (state == RUN) begin
      retire_now = valid_i;
      halt_now   = valid_i & halt_i;
      write_now  = valid_i & reg_write_i & ~halt_i;
      if (ZERO_REG_HARDWIRED && (rd_i == '0)) begin
        write_now = 1'b0;
      end
      if (halt_now) begin
        next_state = HALTED;
      end
    end
  end

  // MEM/WB pipeline register, destination history and statistics counters.
  // In HALTED everything holds except wr_en, which write_now keeps low.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      input_read   <= '0;
      wr_data      <= '0;
      wb_pc        <= '0;
      hist_rd      <= '0;
      hist_vld     <= 2'b00;
      retired_cnt  <= 32'd0;
      regwrite_cnt <= 32'd0;
      load_cnt     <= 32'd0;
    end else begin
      wr_en <= write_now;
      if (state == RUN) begin
        input_read <= rd_i;
        wb_pc      <= pc_i;
        wr_data    <= wb_mux_i ? alu_result_i : mem_data_i;
      end
      if (write_now) begin
        hist_rd  <= {hist_rd[REG_WIDTH-1:0], rd_i};
        hist_vld <= {hist_vld[0], 1'b1};
      end
      if (retire_now) begin
        retired_cnt <= retired_cnt + 32'd1;
        if (write_now) begin
          regwrite_cnt <= regwrite_cnt + 32'd1;
        end
        if (load_i) begin
          load_cnt <= load_cnt + 32'd1;
        end
      end
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Self-checking bench for writeback_stage. Two instances share the same
//   stimulus: one with the default parameters and one with a hardwired zero
//   register. Directed scenarios are followed by a randomized run, and every
//   cycle is compared against a behavioural model of retirement.

module tb_writeback_stage;

  logic        clock;
  logic        rst;
  logic        valid_i;
  logic        reg_write_i;
  logic        wb_mux_i;
  logic        load_i;
  logic        halt_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i;
  logic [31:0] mem_data_i;
  logic [31:0] pc_i;

  logic        wr_en;
  logic [4:0]  input_read;
  logic [31:0] wr_data;
  logic [31:0] wb_pc;
  logic [9:0]  hist_rd;
  logic [1:0]  hist_vld;
  logic [31:0] retired_cnt;
  logic [31:0] regwrite_cnt;
  logic [31:0] load_cnt;
  logic        halted;

  logic        z_wr_en;
  logic [4:0]  z_input_read;
  logic [31:0] z_wr_data;
  logic [31:0] z_wb_pc;
  logic [9:0]  z_hist_rd;
  logic [1:0]  z_hist_vld;
  logic [31:0] z_retired_cnt;
  logic [31:0] z_regwrite_cnt;
  logic [31:0] z_load_cnt;
  logic        z_halted;

  int testCount;
  int failCount;

  // Behavioural model state, index 0 = default instance, 1 = zero-hardwired.
  logic        expWrEn[2];
  logic [4:0]  expRd[2];
  logic [31:0] expData[2];
  logic [31:0] expPc[2];
  logic [31:0] expRetired[2];
  logic [31:0] expRegWrite[2];
  logic [31:0] expLoad[2];
  logic [4:0]  histNewest[2];
  logic [4:0]  histPrevious[2];
  int          histDepth[2];
  logic        expHalted[2];

  writeback_stage #(
    .DATA(32), .REG_WIDTH(5), .ADD_WIDTH(32), .ZERO_REG_HARDWIRED(1'b0)
  ) dut (
    .clock(clock), .rst(rst), .valid_i(valid_i), .reg_write_i(reg_write_i),
    .wb_mux_i(wb_mux_i), .load_i(load_i), .halt_i(halt_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .mem_data_i(mem_data_i), .pc_i(pc_i),
    .wr_en(wr_en), .input_read(input_read), .wr_data(wr_data), .wb_pc(wb_pc),
    .hist_rd(hist_rd), .hist_vld(hist_vld), .retired_cnt(retired_cnt),
    .regwrite_cnt(regwrite_cnt), .load_cnt(load_cnt), .halted(halted)
  );

  writeback_stage #(
    .DATA(32), .REG_WIDTH(5), .ADD_WIDTH(32), .ZERO_REG_HARDWIRED(1'b1)
  ) dut_z (
    .clock(clock), .rst(rst), .valid_i(valid_i), .reg_write_i(reg_write_i),
    .wb_mux_i(wb_mux_i), .load_i(load_i), .halt_i(halt_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .mem_data_i(mem_data_i), .pc_i(pc_i),
    .wr_en(z_wr_en), .input_read(z_input_read), .wr_data(z_wr_data),
    .wb_pc(z_wb_pc), .hist_rd(z_hist_rd), .hist_vld(z_hist_vld),
    .retired_cnt(z_retired_cnt), .regwrite_cnt(z_regwrite_cnt),
    .load_cnt(z_load_cnt), .halted(z_halted)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison in the bench passes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  // Everything the model knows is lost on reset.
  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      expWrEn[k]      = 1'b0;
      expRd[k]        = '0;
      expData[k]      = '0;
      expPc[k]        = '0;
      expRetired[k]   = '0;
      expRegWrite[k]  = '0;
      expLoad[k]      = '0;
      histNewest[k]   = '0;
      histPrevious[k] = '0;
      histDepth[k]    = 0;
      expHalted[k]    = 1'b0;
    end
  endtask

  // Retirement rules for one captured instruction. Once halted nothing
  // changes except that no write is presented.
  task automatic modelStep(input int k);
    logic doWrite;
    if (expHalted[k]) begin
      expWrEn[k] = 1'b0;
    end else begin
      doWrite = valid_i && reg_write_i && !halt_i && !(k == 1 && rd_i == 5'd0);
      expWrEn[k] = doWrite;
      expRd[k]   = rd_i;
      expPc[k]   = pc_i;
      expData[k] = wb_mux_i ? alu_result_i : mem_data_i;
      if (valid_i) begin
        expRetired[k] = expRetired[k] + 1;
        if (doWrite) expRegWrite[k] = expRegWrite[k] + 1;
        if (load_i) expLoad[k] = expLoad[k] + 1;
        if (halt_i) expHalted[k] = 1'b1;
      end
      if (doWrite) begin
        histPrevious[k] = histNewest[k];
        histNewest[k]   = rd_i;
        if (histDepth[k] < 2) histDepth[k] = histDepth[k] + 1;
      end
    end
  endtask

  function automatic logic [1:0] expVld(input int k);
    if (histDepth[k] == 0) return 2'b00;
    if (histDepth[k] == 1) return 2'b01;
    return 2'b11;
  endfunction

  // Compare both instances against the model.
  task automatic checkAll();
    checkOutput("wr_en", {63'd0, wr_en}, {63'd0, expWrEn[0]});
    checkOutput("halted", {63'd0, halted}, {63'd0, expHalted[0]});
    checkOutput("wb_pc", {32'd0, wb_pc}, {32'd0, expPc[0]});
    checkOutput("retired_cnt", {32'd0, retired_cnt}, {32'd0, expRetired[0]});
    checkOutput("regwrite_cnt", {32'd0, regwrite_cnt}, {32'd0, expRegWrite[0]});
    checkOutput("load_cnt", {32'd0, load_cnt}, {32'd0, expLoad[0]});
    checkOutput("hist_vld", {62'd0, hist_vld}, {62'd0, expVld(0)});
    if (histDepth[0] >= 1)
      checkOutput("hist_newest", {59'd0, hist_rd[4:0]}, {59'd0, histNewest[0]});
    if (histDepth[0] == 2)
      checkOutput("hist_prev", {59'd0, hist_rd[9:5]}, {59'd0, histPrevious[0]});
    if (expWrEn[0]) begin
      checkOutput("input_read", {59'd0, input_read}, {59'd0, expRd[0]});
      checkOutput("wr_data", {32'd0, wr_data}, {32'd0, expData[0]});
    end

    checkOutput("z_wr_en", {63'd0, z_wr_en}, {63'd0, expWrEn[1]});
    checkOutput("z_halted", {63'd0, z_halted}, {63'd0, expHalted[1]});
    checkOutput("z_wb_pc", {32'd0, z_wb_pc}, {32'd0, expPc[1]});
    checkOutput("z_retired_cnt", {32'd0, z_retired_cnt}, {32'd0, expRetired[1]});
    checkOutput("z_regwrite_cnt", {32'd0, z_regwrite_cnt}, {32'd0, expRegWrite[1]});
    checkOutput("z_load_cnt", {32'd0, z_load_cnt}, {32'd0, expLoad[1]});
    checkOutput("z_hist_vld", {62'd0, z_hist_vld}, {62'd0, expVld(1)});
    if (histDepth[1] >= 1)
      checkOutput("z_hist_newest", {59'd0, z_hist_rd[4:0]}, {59'd0, histNewest[1]});
    if (histDepth[1] == 2)
      checkOutput("z_hist_prev", {59'd0, z_hist_rd[9:5]}, {59'd0, histPrevious[1]});
    if (expWrEn[1]) begin
      checkOutput("z_input_read", {59'd0, z_input_read}, {59'd0, expRd[1]});
      checkOutput("z_wr_data", {32'd0, z_wr_data}, {32'd0, expData[1]});
    end
  endtask

  // Drive one instruction at the falling edge, let the rising edge capture
  // it, then check at the following falling edge.
  task automatic applyStimulus(input logic v, input logic rw, input logic mux,
                               input logic ld, input logic hlt,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [31:0] pc);
    valid_i      = v;
    reg_write_i  = rw;
    wb_mux_i     = mux;
    load_i       = ld;
    halt_i       = hlt;
    rd_i         = rd;
    alu_result_i = alu;
    mem_data_i   = mem;
    pc_i         = pc;
    @(posedge clock);
    modelStep(0);
    modelStep(1);
    @(negedge clock);
    checkAll();
  endtask

  // Assert reset between edges, check that outputs drop at once, then
  // release at the next falling edge.
  task automatic asyncReset();
    #2;
    rst = 1'b0;
    #1;
    resetModel();
    checkAll();
    checkOutput("rst_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("rst_halted", {63'd0, halted}, 64'd0);
    @(negedge clock);
    rst = 1'b1;
  endtask

  initial begin
    int haltedCycles;
    testCount    = 0;
    failCount    = 0;
    rst          = 1'b0;
    valid_i      = 1'b0;
    reg_write_i  = 1'b0;
    wb_mux_i     = 1'b0;
    load_i       = 1'b0;
    halt_i       = 1'b0;
    rd_i         = '0;
    alu_result_i = '0;
    mem_data_i   = '0;
    pc_i         = '0;
    resetModel();

    #12;
    checkAll();
    checkOutput("reset_retired", {32'd0, retired_cnt}, 64'd0);
    @(negedge clock);
    rst = 1'b1;

    // ALU writeback
    applyStimulus(1, 1, 1, 0, 0, 5'd5, 32'h0000_00AA, 32'h0000_1234, 32'h100);
    checkOutput("alu_wr_en", {63'd0, wr_en}, 64'd1);
    checkOutput("alu_input_read", {59'd0, input_read}, 64'd5);
    checkOutput("alu_wr_data", {32'd0, wr_data}, 64'hAA);
    checkOutput("alu_retired", {32'd0, retired_cnt}, 64'd1);
    checkOutput("alu_regwrite", {32'd0, regwrite_cnt}, 64'd1);
    checkOutput("alu_hist_rd", {59'd0, hist_rd[4:0]}, 64'd5);
    checkOutput("alu_hist_vld", {62'd0, hist_vld}, 64'b01);

    // Load writeback followed by an ALU write to r9
    applyStimulus(1, 1, 0, 1, 0, 5'd7, 32'h1111_2222, 32'hDEAD_BEEF, 32'h104);
    checkOutput("load_wr_data", {32'd0, wr_data}, 64'hDEAD_BEEF);
    checkOutput("load_cnt", {32'd0, load_cnt}, 64'd1);
    applyStimulus(1, 1, 1, 0, 0, 5'd9, 32'h0000_0009, 32'h0, 32'h108);
    checkOutput("hist_pair", {54'd0, hist_rd}, {54'd0, 5'd7, 5'd9});
    checkOutput("hist_pair_vld", {62'd0, hist_vld}, 64'b11);

    // Bubble then a store
    applyStimulus(0, 1, 1, 0, 0, 5'd11, 32'h5, 32'h6, 32'h10C);
    checkOutput("bubble_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("bubble_retired", {32'd0, retired_cnt}, 64'd3);
    applyStimulus(1, 0, 1, 0, 0, 5'd12, 32'h7, 32'h8, 32'h110);
    checkOutput("store_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("store_retired", {32'd0, retired_cnt}, 64'd4);
    checkOutput("store_hist", {54'd0, hist_rd}, {54'd0, 5'd7, 5'd9});

    // Write to r0: allowed by default, dropped with hardwired zero
    applyStimulus(1, 1, 1, 0, 0, 5'd0, 32'h55, 32'h0, 32'h114);
    checkOutput("r0_wr_en", {63'd0, wr_en}, 64'd1);
    checkOutput("r0_input_read", {59'd0, input_read}, 64'd0);
    checkOutput("z_r0_wr_en", {63'd0, z_wr_en}, 64'd0);
    checkOutput("z_r0_retired", {32'd0, z_retired_cnt}, 64'd5);
    checkOutput("z_r0_regwrite", {32'd0, z_regwrite_cnt}, 64'd3);

    // HALT with reg_write set, then three writes that must be ignored
    applyStimulus(1, 1, 1, 0, 1, 5'd3, 32'h33, 32'h0, 32'h118);
    checkOutput("halt_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("halt_halted", {63'd0, halted}, 64'd1);
    checkOutput("halt_retired", {32'd0, retired_cnt}, 64'd6);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 5'(20 + i), 32'h77, 32'h0, 32'h200 + 32'(i));
      checkOutput("frozen_wr_en", {63'd0, wr_en}, 64'd0);
      checkOutput("frozen_retired", {32'd0, retired_cnt}, 64'd6);
    end

    // Asynchronous reset while a write is pending
    asyncReset();
    applyStimulus(1, 1, 1, 0, 0, 5'd4, 32'h44, 32'h0, 32'h300);
    checkOutput("pre_rst_wr_en", {63'd0, wr_en}, 64'd1);
    asyncReset();
    checkOutput("mid_rst_retired", {32'd0, retired_cnt}, 64'd0);
    applyStimulus(1, 1, 1, 0, 0, 5'd2, 32'h22, 32'h0, 32'h304);
    checkOutput("post_rst_retired", {32'd0, retired_cnt}, 64'd1);

    // Randomized traffic; reset a while after a HALT to keep going
    haltedCycles = 0;
    for (int n = 0; n < 600; n++) begin
      if (expHalted[0]) haltedCycles++;
      if (haltedCycles > 4 || $urandom_range(0, 99) == 0) begin
        asyncReset();
        haltedCycles = 0;
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0,
                      ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                      $urandom, $urandom, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
